// File: rtl/inst_loader_pkg.sv
// rtl/inst_loader_pkg.sv - shared constants, mode encodings and FSM state type for the instruction loader
package inst_loader_pkg;

  localparam int          INST_SIZE  = 12;
  localparam int unsigned INST_WORDS = 2 ** INST_SIZE;

  localparam logic [2:0] MODE_STALL = 3'd0;
  localparam logic [2:0] MODE_LOAD  = 3'd1;
  localparam logic [2:0] MODE_EXEC  = 3'd2;

  typedef enum logic [2:0] {
    IDLE,
    HDR,
    BODY,
    SUM,
    DONE,
    ERR
  } loader_state_t;

endpackage

// File: rtl/inst_loader_word_assembler.sv
// rtl/inst_loader_word_assembler.sv - little-endian byte-to-word packer with abort clear
module inst_loader_word_assembler (
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        word_valid,
  output logic [31:0] word
);

  logic [1:0]  cnt_q, cnt_d;
  logic [23:0] buf_q, buf_d;

  // The word completes combinationally on the 4th byte so the consumer can register it with one cycle of latency
  always_comb begin
    cnt_d      = cnt_q;
    buf_d      = buf_q;
    word_valid = 1'b0;
    word       = {byte_data, buf_q};
    if (clear) begin
      cnt_d = 2'd0;
      buf_d = 24'd0;
    end else if (byte_valid) begin
      cnt_d = cnt_q + 2'd1;
      case (cnt_q)
        2'd0:    buf_d[7:0]   = byte_data;
        2'd1:    buf_d[15:8]  = byte_data;
        2'd2:    buf_d[23:16] = byte_data;
        default: word_valid   = 1'b1;
      endcase
    end
  end

  // Byte lane counter and partial-word storage
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= 2'd0;
      buf_q <= 24'd0;
    end else begin
      cnt_q <= cnt_d;
      buf_q <= buf_d;
    end
  end

endmodule

// File: rtl/inst_loader.sv
// rtl/inst_loader.sv - UART program image to INST_BRAM writer; optional trailer checksum via INST_LOADER_CHECKSUM_EN
module inst_loader
  import inst_loader_pkg::*;
#(
  parameter logic [7:0] ACK_OK  = 8'hAA,
  parameter logic [7:0] ACK_ERR = 8'hEE
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [2:0]           mode,
  input  logic [7:0]           rx_data,
  input  logic                 rx_valid,
  output logic [INST_SIZE-1:0] addra,
  output logic [31:0]          dina,
  output logic                 wea,
  output logic [7:0]           tx_data,
  output logic                 tx_valid,
  input  logic                 tx_ready,
  output logic                 done,
  output logic                 err
);

  localparam logic [INST_SIZE:0] IDX_ONE = 1;

  loader_state_t        state_q, state_d;
  logic [INST_SIZE:0]   idx_q, idx_d;
  logic [INST_SIZE:0]   count_q, count_d;
  logic [INST_SIZE-1:0] addra_q, addra_d;
  logic [31:0]          dina_q, dina_d;
  logic                 wea_q, wea_d;
  logic [7:0]           tx_data_q, tx_data_d;
  logic                 tx_valid_q, tx_valid_d;
  logic                 done_q, done_d;
  logic                 err_q, err_d;
`ifdef INST_LOADER_CHECKSUM_EN
  logic [31:0]          sum_q, sum_d;
`endif

  logic                 load_mode;
  logic                 active;
  logic                 word_valid;
  logic [31:0]          word;
  logic [INST_SIZE:0]   idx_next;
  logic                 finish_ok;
  logic                 finish_err;

  assign load_mode = (mode == MODE_LOAD);
  assign active    = (state_q == HDR) || (state_q == BODY) || (state_q == SUM);
  assign idx_next  = idx_q + IDX_ONE;

  // Bytes only reach the assembler while framing; anything else holds it empty
  inst_loader_word_assembler u_asm (
    .clk        (clk),
    .rst        (rst),
    .clear      (!(active && load_mode)),
    .byte_valid (rx_valid && active && load_mode),
    .byte_data  (rx_data),
    .word_valid (word_valid),
    .word       (word)
  );

  // Next-state logic for the framing FSM, BRAM write port and acknowledge
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    count_d    = count_q;
    addra_d    = addra_q;
    dina_d     = dina_q;
    wea_d      = 1'b0;
    tx_data_d  = tx_data_q;
    tx_valid_d = tx_valid_q;
    done_d     = done_q;
    err_d      = err_q;
`ifdef INST_LOADER_CHECKSUM_EN
    sum_d      = sum_q;
`endif
    finish_ok  = 1'b0;
    finish_err = 1'b0;
    case (state_q)
      IDLE: begin
        if (load_mode) begin
          state_d = HDR;
          idx_d   = '0;
          count_d = '0;
`ifdef INST_LOADER_CHECKSUM_EN
          sum_d   = 32'd0;
`endif
        end
      end
      HDR: begin
        if (!load_mode) begin
          state_d = IDLE;
        end else if (word_valid) begin
          if (word == 32'd0) begin
            finish_ok = 1'b1;
          end else if (word > INST_WORDS) begin
            finish_err = 1'b1;
          end else begin
            count_d = word[INST_SIZE:0];
            state_d = BODY;
          end
        end
      end
      BODY: begin
        if (!load_mode) begin
          state_d = IDLE;
        end else if (word_valid) begin
          wea_d   = 1'b1;
          addra_d = idx_q[INST_SIZE-1:0];
          dina_d  = word;
          idx_d   = idx_next;
`ifdef INST_LOADER_CHECKSUM_EN
          sum_d   = sum_q + word;
          if (idx_next == count_q) state_d = SUM;
`else
          if (idx_next == count_q) finish_ok = 1'b1;
`endif
        end
      end
`ifdef INST_LOADER_CHECKSUM_EN
      SUM: begin
        if (!load_mode) begin
          state_d = IDLE;
        end else if (word_valid) begin
          if (word == sum_q) finish_ok = 1'b1;
          else               finish_err = 1'b1;
        end
      end
`endif
      DONE, ERR: begin
        if (tx_valid_q && tx_ready) tx_valid_d = 1'b0;
      end
      default: state_d = IDLE;
    endcase
    // Terminal states are entered only once per reset, so the ack fires exactly once
    if (finish_ok) begin
      state_d    = DONE;
      done_d     = 1'b1;
      tx_data_d  = ACK_OK;
      tx_valid_d = 1'b1;
    end
    if (finish_err) begin
      state_d    = ERR;
      err_d      = 1'b1;
      tx_data_d  = ACK_ERR;
      tx_valid_d = 1'b1;
    end
  end

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      count_q    <= '0;
      addra_q    <= '0;
      dina_q     <= 32'd0;
      wea_q      <= 1'b0;
      tx_data_q  <= 8'd0;
      tx_valid_q <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
`ifdef INST_LOADER_CHECKSUM_EN
      sum_q      <= 32'd0;
`endif
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      count_q    <= count_d;
      addra_q    <= addra_d;
      dina_q     <= dina_d;
      wea_q      <= wea_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      done_q     <= done_d;
      err_q      <= err_d;
`ifdef INST_LOADER_CHECKSUM_EN
      sum_q      <= sum_d;
`endif
    end
  end

  assign addra    = addra_q;
  assign dina     = dina_q;
  assign wea      = wea_q;
  assign tx_data  = tx_data_q;
  assign tx_valid = tx_valid_q;
  assign done     = done_q;
  assign err      = err_q;

endmodule
